// File: rtl/memory_dp_be.sv
// True dual-port RAM with byte-lane write enables, 1- or 2-cycle read latency,
// deterministic same-address collision handling and a zeroing clear engine.
module memory_dp_be #(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clr_i,
    output logic                    busy_o,
    input  logic                    ena_i,
    input  logic [DATA_WIDTH/8-1:0] wea_i,
    input  logic [ADDR_WIDTH-1:0]   addra_i,
    input  logic [DATA_WIDTH-1:0]   dia_i,
    output logic [DATA_WIDTH-1:0]   doa_o,
    output logic                    rvalida_o,
    input  logic                    enb_i,
    input  logic [DATA_WIDTH/8-1:0] web_i,
    input  logic [ADDR_WIDTH-1:0]   addrb_i,
    input  logic [DATA_WIDTH-1:0]   dib_i,
    output logic [DATA_WIDTH-1:0]   dob_o,
    output logic                    rvalidb_o,
    output logic                    collision_o
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic {
        CLEAR,
        IDLE
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    busy;
    logic                    acceptA, acceptB;
    logic                    wrA, wrB, rdA, rdB;
    logic                    sameAddr;

    logic [DATA_WIDTH-1:0]   rdDataA_q, rdDataB_q;
    logic                    rdValidA_q, rdValidB_q;
    logic                    collision_q;

    assign busy   = (state_q == CLEAR);
    assign busy_o = busy;

    // A clr arriving in IDLE blocks port requests at the same edge, so nothing
    // can slip in underneath the clear that is about to start.
    assign acceptA  = ena_i & ~busy & ~clr_i;
    assign acceptB  = enb_i & ~busy & ~clr_i;
    assign wrA      = acceptA & (|wea_i);
    assign wrB      = acceptB & (|web_i);
    assign rdA      = acceptA & ~(|wea_i);
    assign rdB      = acceptB & ~(|web_i);
    assign sameAddr = (addra_i == addrb_i);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (clr_i) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Array is deliberately not reset; port A owns any lane both ports write.
    always_ff @(posedge clk_i) begin
        if (busy) begin
            mem_q[cnt_q] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (acceptA && wea_i[i]) begin
                    mem_q[addra_i][8*i +: 8] <= dia_i[8*i +: 8];
                end
                if (acceptB && web_i[i] && !(acceptA && wea_i[i] && sameAddr)) begin
                    mem_q[addrb_i][8*i +: 8] <= dib_i[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdDataA_q   <= '0;
            rdDataB_q   <= '0;
            rdValidA_q  <= 1'b0;
            rdValidB_q  <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            if (rdA) begin
                rdDataA_q <= mem_q[addra_i];
            end
            if (rdB) begin
                rdDataB_q <= mem_q[addrb_i];
            end
            rdValidA_q  <= rdA;
            rdValidB_q  <= rdB;
            collision_q <= acceptA & acceptB & sameAddr & (wrA | wrB);
        end
    end

    assign collision_o = collision_q;

    if (READ_LATENCY == 2) begin : gen_lat2
        logic [DATA_WIDTH-1:0] outDataA_q, outDataB_q;
        logic                  outValidA_q, outValidB_q;

        // Output stage only advances on a valid word so dout holds between reads.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                outDataA_q  <= '0;
                outDataB_q  <= '0;
                outValidA_q <= 1'b0;
                outValidB_q <= 1'b0;
            end else begin
                if (rdValidA_q) begin
                    outDataA_q <= rdDataA_q;
                end
                if (rdValidB_q) begin
                    outDataB_q <= rdDataB_q;
                end
                outValidA_q <= rdValidA_q;
                outValidB_q <= rdValidB_q;
            end
        end

        assign doa_o     = outDataA_q;
        assign dob_o     = outDataB_q;
        assign rvalida_o = outValidA_q;
        assign rvalidb_o = outValidB_q;
    end else begin : gen_lat1
        assign doa_o     = rdDataA_q;
        assign dob_o     = rdDataB_q;
        assign rvalida_o = rdValidA_q;
        assign rvalidb_o = rdValidB_q;
    end

endmodule

// File: tb/tb_memory_dp_be.sv
// Scoreboard bench: identical traffic drives a latency-1 and a latency-2 RAM;
// expected reads and collisions are queued at issue time and popped by monitors.
module tb_memory_dp_be;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        ena = 1'b0, enb = 1'b0;
    logic [3:0]  wea = '0, web = '0;
    logic [3:0]  addra = '0, addrb = '0;
    logic [31:0] dia = '0, dib = '0;

    logic        busy1, busy2, rva1, rvb1, rva2, rvb2, coll1, coll2;
    logic [31:0] doa1, dob1, doa2, dob2;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int n;

    exp_t qA1[$], qB1[$], qA2[$], qB2[$];
    int   qC1[$], qC2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    memory_dp_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .READ_LATENCY(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .busy_o(busy1),
        .ena_i(ena), .wea_i(wea), .addra_i(addra), .dia_i(dia),
        .doa_o(doa1), .rvalida_o(rva1),
        .enb_i(enb), .web_i(web), .addrb_i(addrb), .dib_i(dib),
        .dob_o(dob1), .rvalidb_o(rvb1), .collision_o(coll1)
    );

    memory_dp_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .READ_LATENCY(2)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .busy_o(busy2),
        .ena_i(ena), .wea_i(wea), .addra_i(addra), .dia_i(dia),
        .doa_o(doa2), .rvalida_o(rva2),
        .enb_i(enb), .web_i(web), .addrb_i(addrb), .dib_i(dib),
        .dob_o(dob2), .rvalidb_o(rvb2), .collision_o(coll2)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one request cycle; inputs change 1 time unit after a rising edge.
    task automatic applyStimulus(input logic eA, input logic [3:0] wA, input logic [3:0] aA,
                                 input logic [31:0] dA, input logic eB, input logic [3:0] wB,
                                 input logic [3:0] aB, input logic [31:0] dB);
        ena = eA; wea = wA; addra = aA; dia = dA;
        enb = eB; web = wB; addrb = aB; dib = dB;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    endtask

    task automatic expectRead(input bit portB, input logic [31:0] d);
        exp_t e1, e2;
        e1.data = d; e1.due = cyc + 1;
        e2.data = d; e2.due = cyc + 2;
        if (portB) begin
            qB1.push_back(e1); qB2.push_back(e2);
        end else begin
            qA1.push_back(e1); qA2.push_back(e2);
        end
    endtask

    task automatic expectColl();
        qC1.push_back(cyc + 1);
        qC2.push_back(cyc + 1);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " busy1"}, busy1, 1'b1);
        checkOutput({tag, " busy2"}, busy2, 1'b1);
        checkOutput({tag, " doa1"}, doa1, 32'h0);
        checkOutput({tag, " dob1"}, dob1, 32'h0);
        checkOutput({tag, " doa2"}, doa2, 32'h0);
        checkOutput({tag, " dob2"}, dob2, 32'h0);
        checkOutput({tag, " rvalid1"}, {rva1, rvb1}, 2'b00);
        checkOutput({tag, " rvalid2"}, {rva2, rvb2}, 2'b00);
        checkOutput({tag, " collision"}, {coll1, coll2}, 2'b00);
    endtask

    task automatic waitClear(input string tag);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (busy1 && n < 100);
        checkOutput({tag, " busy cycles"}, n, 16);
        checkOutput({tag, " busy2 low"}, busy2, 1'b0);
    endtask

    `define MON_READ(Q, V, D, TAG) \
    always @(negedge clk) begin \
        exp_t e; \
        if (rst_n) begin \
            if (V) begin \
                if (Q.size() == 0) begin \
                    checkOutput({TAG, " spurious rvalid"}, V, 1'b0); \
                end else begin \
                    e = Q.pop_front(); \
                    checkOutput({TAG, " data"}, D, e.data); \
                    checkOutput({TAG, " arrival cycle"}, cyc, e.due); \
                end \
            end else if (Q.size() > 0 && Q[0].due <= cyc) begin \
                e = Q.pop_front(); \
                checkOutput({TAG, " missing rvalid"}, V, 1'b1); \
            end \
        end \
    end

    `define MON_COLL(Q, V, TAG) \
    always @(negedge clk) begin \
        int d; \
        if (rst_n) begin \
            if (V) begin \
                if (Q.size() == 0) begin \
                    checkOutput({TAG, " spurious collision"}, V, 1'b0); \
                end else begin \
                    d = Q.pop_front(); \
                    checkOutput({TAG, " collision cycle"}, cyc, d); \
                end \
            end else if (Q.size() > 0 && Q[0] <= cyc) begin \
                d = Q.pop_front(); \
                checkOutput({TAG, " missing collision"}, V, 1'b1); \
            end \
        end \
    end

    `MON_READ(qA1, rva1, doa1, "A lat1")
    `MON_READ(qB1, rvb1, dob1, "B lat1")
    `MON_READ(qA2, rva2, doa2, "A lat2")
    `MON_READ(qB2, rvb2, dob2, "B lat2")
    `MON_COLL(qC1, coll1, "lat1")
    `MON_COLL(qC2, coll2, "lat2")

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout actual=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkResetValues("reset");
        rst_n = 1'b1;
        waitClear("power-up clear");

        for (int i = 0; i < 16; i++) begin
            expectRead(1'b0, 32'h0);
            applyStimulus(1'b1, 4'h0, 4'(i), 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
        end
        idle();

        applyStimulus(1'b1, 4'hF, 4'd3, 32'hDEADBEEF, 1'b0, 4'h0, 4'h0, 32'h0);
        applyStimulus(1'b1, 4'h5, 4'd3, 32'h11223344, 1'b0, 4'h0, 4'h0, 32'h0);
        expectRead(1'b1, 32'hDE22BE44);
        applyStimulus(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h0, 4'd3, 32'h0);
        idle();

        // Back-to-back reads on both ports, including a same-address read pair.
        applyStimulus(1'b1, 4'hF, 4'd1, 32'h11111111, 1'b1, 4'hF, 4'd2, 32'h22222222);
        expectRead(1'b0, 32'h11111111); expectRead(1'b1, 32'hDE22BE44);
        applyStimulus(1'b1, 4'h0, 4'd1, 32'h0, 1'b1, 4'h0, 4'd3, 32'h0);
        expectRead(1'b0, 32'h22222222); expectRead(1'b1, 32'h22222222);
        applyStimulus(1'b1, 4'h0, 4'd2, 32'h0, 1'b1, 4'h0, 4'd2, 32'h0);
        expectRead(1'b0, 32'hDE22BE44); expectRead(1'b1, 32'h11111111);
        applyStimulus(1'b1, 4'h0, 4'd3, 32'h0, 1'b1, 4'h0, 4'd1, 32'h0);
        repeat (4) idle();
        checkOutput("doa hold lat1", doa1, 32'hDE22BE44);
        checkOutput("doa hold lat2", doa2, 32'hDE22BE44);
        checkOutput("dob hold lat2", dob2, 32'h11111111);

        expectColl();
        applyStimulus(1'b1, 4'h3, 4'd7, 32'hAAAAAAAA, 1'b1, 4'hF, 4'd7, 32'hBBBBBBBB);
        expectRead(1'b0, 32'hBBBBAAAA); expectColl();
        applyStimulus(1'b1, 4'h0, 4'd7, 32'h0, 1'b1, 4'hF, 4'd7, 32'hCAFEF00D);
        expectRead(1'b1, 32'hCAFEF00D); expectColl();
        applyStimulus(1'b1, 4'h1, 4'd7, 32'h00000055, 1'b1, 4'h0, 4'd7, 32'h0);
        expectRead(1'b0, 32'hCAFEF055);
        applyStimulus(1'b1, 4'h0, 4'd7, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
        repeat (3) idle();

        // Clear during traffic: an in-flight read completes, nothing after clr lands.
        applyStimulus(1'b1, 4'hF, 4'd5, 32'h12345678, 1'b0, 4'h0, 4'h0, 32'h0);
        expectRead(1'b0, 32'h12345678);
        applyStimulus(1'b1, 4'h0, 4'd5, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
        clr = 1'b1;
        applyStimulus(1'b1, 4'hF, 4'd5, 32'hFFFFFFFF, 1'b1, 4'h0, 4'd5, 32'h0);
        n = 0;
        do begin
            clr = (n == 5);
            applyStimulus(1'b1, 4'hF, 4'd5, 32'hFFFFFFFF, 1'b1, 4'h0, 4'd5, 32'h0);
            n++;
        end while (busy1 && n < 100);
        clr = 1'b0;
        checkOutput("clr busy cycles", n, 16);
        expectRead(1'b0, 32'h0); expectRead(1'b1, 32'h0);
        applyStimulus(1'b1, 4'h0, 4'd5, 32'h0, 1'b1, 4'h0, 4'd7, 32'h0);
        repeat (3) idle();

        applyStimulus(1'b1, 4'hF, 4'd9, 32'h99999999, 1'b0, 4'h0, 4'h0, 32'h0);
        expectRead(1'b0, 32'h99999999);
        applyStimulus(1'b1, 4'h0, 4'd9, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
        repeat (3) idle();
        clr = 1'b1;
        idle();
        clr = 1'b0;
        repeat (7) idle();
        rst_n = 1'b0;
        #1;
        checkResetValues("mid-clear reset");
        repeat (2) idle();
        rst_n = 1'b1;
        waitClear("restarted clear");
        expectRead(1'b0, 32'h0); expectRead(1'b1, 32'h0);
        applyStimulus(1'b1, 4'h0, 4'd9, 32'h0, 1'b1, 4'h0, 4'd15, 32'h0);
        repeat (4) idle();

        checkOutput("queue A lat1 drained", qA1.size(), 0);
        checkOutput("queue B lat1 drained", qB1.size(), 0);
        checkOutput("queue A lat2 drained", qA2.size(), 0);
        checkOutput("queue B lat2 drained", qB2.size(), 0);
        checkOutput("collision queues drained", qC1.size() + qC2.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_dp_be.md
# memory_dp_be

Parametrised true-dual-port block RAM, successor to the fixed 32-bit dual-port memory. Adds configurable data width with per-byte write enables, selectable read latency, per-port read-valid strobes, deterministic cross-port collision handling and a hardware clear engine that zeroes the array after reset or on request. Serves as shared instruction/data storage between core and DMA/test ports.

## Interface
- ADDR_WIDTH, 10, address bits; depth = 2**ADDR_WIDTH words
- DATA_WIDTH, 32, word width; must be a multiple of 8; NB = DATA_WIDTH/8 byte lanes
- READ_LATENCY, 1, 1 or 2 cycles from read request to data (2 adds an output register)
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  single-cycle request to zero the whole array
- busy  out  1  high while the clear engine runs; port requests ignored
- ena  in  1  port A enable
- wea  in  NB  port A byte write enables; all-zero = read
- addra  in  ADDR_WIDTH  port A address
- dia  in  DATA_WIDTH  port A write data, little-endian lanes (lane i = bits 8i+7:8i)
- doa  out  DATA_WIDTH  port A read data
- rvalida  out  1  doa holds fresh read data this cycle
- enb, web, addrb, dib, dob, rvalidb: port B, identical to port A
- collision  out  1  registered pulse: both ports enabled on same address same cycle with at least one writing

## Operation
- Accept condition per port: en=1 and busy=0. Non-accepted requests have no effect and produce no rvalid.
- Write (accepted, we!=0): lane i of addressed word updated from din lane i where we[i]=1; other lanes unchanged. dout and rvalid unaffected.
- Read (accepted, we=0): word returned on dout after READ_LATENCY; dout holds last value until the next read completes.
- Cross-port same address, same cycle:
  - both write: per lane, port A wins where wea[i]=1; port B lanes applied where wea[i]=0 and web[i]=1.
  - one reads, other writes: read returns old (pre-write) data.
  - both read: both return the word, no collision.
  - collision asserted one cycle later for the two write cases above.
- Clear engine FSM, states CLEAR and IDLE:
  - reset → CLEAR with counter 0; each cycle writes all-zero to address counter, counter+1.
  - CLEAR → IDLE after writing address 2**ADDR_WIDTH-1 (counter wraps to 0).
  - IDLE → CLEAR when clr=1; clr in CLEAR ignored (no restart).
  - busy = (state==CLEAR).
- Array contents not reset by rst_n directly; only cleared by the engine.

## Timing
- Reset values: doa=0, dob=0, rvalida=0, rvalidb=0, collision=0, busy=1 (state CLEAR, counter 0).
- Clear duration: exactly 2**ADDR_WIDTH cycles; busy falls on the cycle after the last address is written; a request presented in the first busy=0 cycle is accepted.
- clr accepted in IDLE at edge N → busy=1 from N+1; no port request accepted at edge N or later until clear ends. Port requests accepted at edge N-1 complete normally.
- READ_LATENCY=1: read at edge N → dout and rvalid=1 after edge N+1 (visible during cycle N+1); rvalid low next cycle unless another read.
- READ_LATENCY=2: as above but one cycle later; back-to-back reads give one word per cycle.
- Reads in flight when clear starts still complete with pre-clear data.
- rst_n low mid-operation: outputs to reset values immediately, in-flight reads dropped, clear restarts from address 0 on release.
- Collision pulse: one cycle, after the edge at which both requests were accepted.

## Test plan
- Reset/clear, ADDR_WIDTH=4: release rst_n → busy high 16 cycles, then low; read all 16 addresses → all 0x00000000, rvalida pulses each read.
- Byte lanes: write 0xDEADBEEF to addr 3 (wea=1111), then wea=0101 with 0x11223344 → read addr 3 on port B = 0xDE22BE44.
- Latency: READ_LATENCY=2, reads at addr 1,2,3 on consecutive edges → rvalida high three consecutive cycles starting edge+2, data in order.
- Collision: A writes 0xAAAA_AAAA wea=0011, B writes 0xBBBB_BBBB web=1111, same addr → stored 0xBBBBAAAA, collision=1 for one cycle; A read + B write same addr → A gets old word, collision=1.
- clr mid-traffic: write 0x12345678 to addr 5, pulse clr, drive ena every cycle during busy → no writes land, no rvalid; after clear addr 5 reads 0.
- Reset mid-clear: drop rst_n at clear counter 7 → outputs zero, busy=1; after release full 16-cycle clear repeats.
